// File: rtl/complex_fu_wb_pipe_pkg.sv
// Shared widths, flag positions and payload sizing for the complex-ALU writeback pipe.
package complex_fu_wb_pipe_pkg;

   localparam int SIZE_DATA       = 32;
   localparam int EXECUTION_FLAGS = 6;
   localparam int PHY_TAG_W       = 7;
   localparam int AL_ID_W         = 7;

   localparam int FLAG_EXECUTED   = 0;
   localparam int FLAG_EXCEPTION  = 1;
   localparam int FLAG_MISPREDICT = 2;

   typedef struct packed {
      logic [2*SIZE_DATA-1:0]     result;
      logic [EXECUTION_FLAGS-1:0] flags;
      logic [PHY_TAG_W-1:0]       dest_tag;
      logic [AL_ID_W-1:0]         al_id;
   } wb_payload_t;

   function automatic int payload_w(input int data_w, input int flag_w,
                                    input int tag_w, input int al_w);
      return 2*data_w + flag_w + tag_w + al_w;
   endfunction

endpackage

// File: rtl/complex_fu_wb_pipe_if.sv
// Issue-side and writeback-side signal bundle of the complex-ALU result pipe.
interface complex_fu_wb_pipe_if #(
   parameter int DATA_W = complex_fu_wb_pipe_pkg::SIZE_DATA,
   parameter int FLAG_W = complex_fu_wb_pipe_pkg::EXECUTION_FLAGS,
   parameter int TAG_W  = complex_fu_wb_pipe_pkg::PHY_TAG_W,
   parameter int AL_W   = complex_fu_wb_pipe_pkg::AL_ID_W
);
   logic                flush_i;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [2*DATA_W-1:0] result_i;
   logic [FLAG_W-1:0]   flags_i;
   logic [TAG_W-1:0]    dest_tag_i;
   logic [AL_W-1:0]     al_id_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [2*DATA_W-1:0] out_result_o;
   logic [FLAG_W-1:0]   out_flags_o;
   logic [TAG_W-1:0]    out_dest_tag_o;
   logic [AL_W-1:0]     out_al_id_o;
   logic                busy_o;

   modport master (
      output flush_i, in_valid_i, result_i, flags_i, dest_tag_i, al_id_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_result_o, out_flags_o, out_dest_tag_o,
             out_al_id_o, busy_o
   );

   modport slave (
      input  flush_i, in_valid_i, result_i, flags_i, dest_tag_i, al_id_i, out_ready_i,
      output in_ready_o, out_valid_o, out_result_o, out_flags_o, out_dest_tag_o,
             out_al_id_o, busy_o
   );
endinterface

// File: rtl/complex_fu_wb_pipe_fifo.sv
// In-order output buffer; full/empty come from index pointers plus a wrap bit, so any depth works.
module complex_wb_fifo #(
   parameter int W     = 84,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty
);
   import complex_fu_wb_pipe_pkg::*;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_idx, r_rd_idx;
   logic          r_wr_wrap, r_rd_wrap;
   logic          w_full;
   logic          w_pop;

   // Index wraps at DEPTH-1 rather than at a power of two; the wrap bit toggles instead.
   function automatic logic [AW:0] ptr_next(input logic wrap, input logic [AW-1:0] idx);
      if (idx == AW'(DEPTH-1)) return {~wrap, {AW{1'b0}}};
      else                     return {wrap, idx + AW'(1)};
   endfunction

   assign empty  = (r_wr_idx == r_rd_idx) && (r_wr_wrap == r_rd_wrap);
   assign w_full = (r_wr_idx == r_rd_idx) && (r_wr_wrap != r_rd_wrap);
   assign w_pop  = pop & ~empty;
   assign dout   = empty ? '0 : r_mem[r_rd_idx];

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_idx] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_idx  <= '0;
         r_wr_wrap <= 1'b0;
         r_rd_idx  <= '0;
         r_rd_wrap <= 1'b0;
      end else begin
         if (push)  {r_wr_wrap, r_wr_idx} <= ptr_next(r_wr_wrap, r_wr_idx);
         if (w_pop) {r_rd_wrap, r_rd_idx} <= ptr_next(r_rd_wrap, r_rd_idx);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
                                   push |-> (!w_full || w_pop));

endmodule

// File: rtl/complex_fu_wb_pipe.sv
// Fixed-latency delay line for complex-ALU results feeding a credit-protected writeback buffer.
module complex_fu_wb_pipe
   import complex_fu_wb_pipe_pkg::*;
#(
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = SIZE_DATA,
   parameter int FLAG_W     = EXECUTION_FLAGS,
   parameter int TAG_W      = PHY_TAG_W,
   parameter int AL_W       = AL_ID_W
) (
   input logic               clk,
   input logic               reset,
   complex_fu_wb_pipe_if.slave bus
);
   localparam int PW = payload_w(DATA_W, FLAG_W, TAG_W, AL_W);
   localparam int OW = $clog2(FIFO_DEPTH + 1);

   logic [PW-1:0] w_in_pay, w_push_pay, w_head_pay;
   logic          w_accept, w_fire, w_push, w_empty, w_out_valid, w_in_ready;
   logic          w_kill;
   logic [OW-1:0] r_occ;

   assign w_kill      = reset | bus.flush_i;
   assign w_in_pay    = {bus.result_i, bus.flags_i, bus.dest_tag_i, bus.al_id_i};
   assign w_in_ready  = (r_occ < OW'(FIFO_DEPTH));
   assign w_out_valid = ~w_empty;
   assign w_accept    = bus.in_valid_i & w_in_ready;
   assign w_fire      = w_out_valid & bus.out_ready_i;

   // Stage p0 captures the accepted op; the last stage feeds the buffer.
   if (LAT > 1) begin : g_pipe
      logic          r_vld_p [LAT-1];
      logic [PW-1:0] r_pay_p [LAT-1];

      always_ff @(posedge clk) begin
         if (w_kill) begin
            for (int i = 0; i < LAT-1; i++) r_vld_p[i] <= 1'b0;
         end else begin
            r_vld_p[0] <= w_accept;
            for (int i = 1; i < LAT-1; i++) r_vld_p[i] <= r_vld_p[i-1];
         end
      end

      always_ff @(posedge clk) begin
         r_pay_p[0] <= w_in_pay;
         for (int i = 1; i < LAT-1; i++) r_pay_p[i] <= r_pay_p[i-1];
      end

      assign w_push     = r_vld_p[LAT-2];
      assign w_push_pay = r_pay_p[LAT-2];
   end else begin : g_nopipe
      assign w_push     = w_accept;
      assign w_push_pay = w_in_pay;
   end

   // Credit count covers pipe plus buffer, so an accepted op always has a slot waiting.
   always_ff @(posedge clk) begin
      if (w_kill) begin
         r_occ <= '0;
      end else begin
         case ({w_accept, w_fire})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   complex_wb_fifo #(
      .W     (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .flush (bus.flush_i),
      .push  (w_push),
      .din   (w_push_pay),
      .pop   (w_fire),
      .dout  (w_head_pay),
      .empty (w_empty)
   );

   assign bus.in_ready_o  = w_in_ready;
   assign bus.out_valid_o = w_out_valid;
   assign bus.busy_o      = (r_occ != '0);
   assign {bus.out_result_o, bus.out_flags_o, bus.out_dest_tag_o, bus.out_al_id_o} = w_head_pay;

endmodule

// File: tb/tb_complex_fu_wb_pipe.sv
// Randomized bench for two pipe configurations (LAT=3/DEPTH=4 and LAT=1/DEPTH=1) against a queue model.
module tb_complex_fu_wb_pipe;
   import complex_fu_wb_pipe_pkg::*;

   localparam int PW = payload_w(SIZE_DATA, EXECUTION_FLAGS, PHY_TAG_W, AL_ID_W);

   typedef struct {
      logic [PW-1:0] pay;
      int            rdy;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   complex_fu_wb_pipe_if bus0 ();
   complex_fu_wb_pipe_if bus1 ();

   complex_fu_wb_pipe #(.LAT(3), .FIFO_DEPTH(4)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   complex_fu_wb_pipe #(.LAT(1), .FIFO_DEPTH(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

   int lat [2] = '{3, 1};
   int dep [2] = '{4, 1};
   ent_t mq [2][$];

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;

   logic          ov [2], ir [2], bz [2];
   logic [PW-1:0] op [2];

   assign ov[0] = bus0.out_valid_o;
   assign ir[0] = bus0.in_ready_o;
   assign bz[0] = bus0.busy_o;
   assign op[0] = {bus0.out_result_o, bus0.out_flags_o, bus0.out_dest_tag_o, bus0.out_al_id_o};
   assign ov[1] = bus1.out_valid_o;
   assign ir[1] = bus1.in_ready_o;
   assign bz[1] = bus1.busy_o;
   assign op[1] = {bus1.out_result_o, bus1.out_flags_o, bus1.out_dest_tag_o, bus1.out_al_id_o};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic head_ready(input int k);
      return (mq[k].size() > 0) && (mq[k][0].rdy <= cyc);
   endfunction

   function automatic logic [PW-1:0] rnd_pay();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return {r, 6'($urandom), 7'($urandom), 7'($urandom)};
   endfunction

   task automatic check_all(input string ph);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.i%0d.out_valid", ph, k), 128'(ov[k]), 128'(head_ready(k)));
         chk($sformatf("%s.i%0d.in_ready", ph, k), 128'(ir[k]), 128'(mq[k].size() < dep[k]));
         chk($sformatf("%s.i%0d.busy", ph, k), 128'(bz[k]), 128'(mq[k].size() != 0));
         chk($sformatf("%s.i%0d.payload", ph, k), 128'(op[k]),
             head_ready(k) ? 128'(mq[k][0].pay) : 128'(0));
      end
   endtask

   // One clock: check the state left by the previous edge, drive, advance model and clock.
   task automatic cycle(input string ph, input logic v, input logic r0, input logic r1,
                        input logic fl, input logic rs, input logic [PW-1:0] pay);
      logic rr [2];
      logic acc, fire;
      check_all(ph);
      rr[0] = r0;
      rr[1] = r1;
      reset = rs;
      bus0.flush_i = fl;     bus1.flush_i = fl;
      bus0.in_valid_i = v;   bus1.in_valid_i = v;
      bus0.out_ready_i = r0; bus1.out_ready_i = r1;
      {bus0.result_i, bus0.flags_i, bus0.dest_tag_i, bus0.al_id_i} = pay;
      {bus1.result_i, bus1.flags_i, bus1.dest_tag_i, bus1.al_id_i} = pay;
      for (int k = 0; k < 2; k++) begin
         acc  = v && (mq[k].size() < dep[k]);
         fire = head_ready(k) && rr[k];
         if (fire) void'(mq[k].pop_front());
         if (acc) mq[k].push_back('{pay: pay, rdy: cyc + lat[k]});
         if (fl || rs) mq[k].delete();
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   logic [PW-1:0] single_pay;

   initial begin
      reset = 1'b1;
      bus0.flush_i = 1'b0;    bus1.flush_i = 1'b0;
      bus0.in_valid_i = 1'b0; bus1.in_valid_i = 1'b0;
      bus0.out_ready_i = 1'b0; bus1.out_ready_i = 1'b0;
      {bus0.result_i, bus0.flags_i, bus0.dest_tag_i, bus0.al_id_i} = '0;
      {bus1.result_i, bus1.flags_i, bus1.dest_tag_i, bus1.al_id_i} = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      single_pay = {64'h0000_0000_0000_0006, 6'b000001, 7'd5, 7'd9};

      cycle("single", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, single_pay);
      for (int i = 0; i < 6; i++) cycle("single", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 8; i++) cycle("stream", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());
      for (int i = 0; i < 5; i++) cycle("stream", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 8; i++) cycle("bkpr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
      cycle("bkpr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());
      for (int i = 0; i < 4; i++) cycle("bkpr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
      for (int i = 0; i < 10; i++) cycle("bkpr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 3; i++) cycle("flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
      cycle("flush", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rnd_pay());
      for (int i = 0; i < 6; i++) cycle("flush", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 3; i++) cycle("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());
      cycle("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rnd_pay());
      cycle("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, single_pay);
      for (int i = 0; i < 5; i++) cycle("midrst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 12; i++)
         cycle("alt", 1'(i % 2 == 0), 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());
      cycle("alt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
      cycle("alt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pay());
      for (int i = 0; i < 5; i++) cycle("alt", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());

      for (int i = 0; i < 600; i++)
         cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0),
               1'($urandom_range(0, 150) == 0), rnd_pay());
      for (int i = 0; i < 10; i++) cycle("drain", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd_pay());
      check_all("final");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
